// File: rtl/sram_pkg.sv
// Shared constants and state type for the SRAM read-side controller.
package sram_pkg;

  localparam real VDD              = 1.5;
  localparam real VSS              = 0.0;
  localparam real VTH              = 0.8;
  localparam real SENSE_MARGIN_DEF = 0.4;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    WORDLINE,
    SENSE,
    RESP
  } rd_state_t;

endpackage

// File: rtl/sram_sense_amp.sv
// Per-column differential sense amplifier: samples bl-blb on enable and
// registers the resolved bit plus an undetermined-sense flag.
module sram_sense_amp
  import sram_pkg::*;
#(
  parameter real MARGIN = SENSE_MARGIN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  real  bl,
  input  real  blb,
  output logic bit_q,
  output logic err_q
);

  logic bit_d;
  logic err_d;
  real  diff;

  always_comb begin
    diff  = bl - blb;
    bit_d = bit_q;
    err_d = err_q;
    if (sample_en) begin
      if (diff >= MARGIN) begin
        bit_d = 1'b1;
        err_d = 1'b0;
      end else if (diff <= -MARGIN) begin
        bit_d = 1'b0;
        err_d = 1'b0;
      end else begin
        bit_d = 1'b0;
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/sram_read_ctrl.sv
// Read sequencer for the SRAM array: precharge, wordline pulse, sense, and
// hold the response until the consumer accepts it.
module sram_read_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 8,
  parameter int unsigned PRE_CYCLES   = 2,
  parameter int unsigned WL_CYCLES    = 2,
  parameter real         SENSE_MARGIN = SENSE_MARGIN_DEF,
  localparam int unsigned AW          = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  output logic            pre_en,
  output logic [ROWS-1:0] row_rd,
  input  real             bl_rd  [COLS],
  input  real             blb_rd [COLS],
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [COLS-1:0] rsp_data,
  output logic [COLS-1:0] rsp_err
);

  localparam int unsigned CNT_MAX = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  rd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            req_ready_d, pre_en_d, rsp_valid_d;
  logic [ROWS-1:0] row_rd_d;
  logic            accept, addr_ok, sense_sel, sample_en;

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    accept    = req_valid && req_ready;
    addr_ok   = 32'(req_addr) < ROWS;
    sense_sel = (state_q == SENSE);
    sample_en = sense_sel;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          cnt_d  = '0;
          if (addr_ok) begin
            state_d = PRECHARGE;
          end else begin
            // Out-of-range row: sense both rails at VSS so every column flags err.
            state_d   = RESP;
            sample_en = 1'b1;
          end
        end
      end
      PRECHARGE: begin
        if (cnt_q == CNT_W'(PRE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = WORDLINE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WORDLINE: begin
        if (cnt_q == CNT_W'(WL_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = SENSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SENSE: state_d = RESP;
      RESP: begin
        if (rsp_valid && rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    pre_en_d    = (state_d == PRECHARGE);
    rsp_valid_d = (state_d == RESP);
    row_rd_d    = '0;
    if (state_d == WORDLINE || state_d == SENSE) row_rd_d = ROWS'(1) << addr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      req_ready <= 1'b0;
      pre_en    <= 1'b0;
      row_rd    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      req_ready <= req_ready_d;
      pre_en    <= pre_en_d;
      row_rd    <= row_rd_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    sram_sense_amp #(
      .MARGIN(SENSE_MARGIN)
    ) u_sa (
      .clk      (clk),
      .rst      (rst),
      .sample_en(sample_en),
      .bl       (sense_sel ? bl_rd[c]  : VSS),
      .blb      (sense_sel ? blb_rd[c] : VSS),
      .bit_q    (rsp_data[c]),
      .err_q    (rsp_err[c])
    );
  end

endmodule

// File: tb/tb_sram_read_ctrl.sv
// Directed plus randomized bench for sram_read_ctrl against a timeline and
// differential-sense reference model.
module tb_sram_read_ctrl;

  localparam int PRE = 2;
  localparam int WL  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         last_acc = 0;
  int         first_acc = 0;

  logic       req_valid = 1'b0, rsp_ready = 1'b0;
  logic [1:0] req_addr = '0;
  logic       req_ready, pre_en, rsp_valid;
  logic [3:0] row_rd;
  logic [1:0] rsp_data, rsp_err;

  logic       req_valid3 = 1'b0, rsp_ready3 = 1'b0;
  logic [1:0] req_addr3 = '0;
  logic       req_ready3, pre_en3, rsp_valid3;
  logic [2:0] row_rd3;
  logic [1:0] rsp_data3, rsp_err3;

  real bl  [2];
  real blb [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_read_ctrl #(.ROWS(4), .COLS(2), .PRE_CYCLES(PRE), .WL_CYCLES(WL), .SENSE_MARGIN(0.4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .pre_en(pre_en), .row_rd(row_rd), .bl_rd(bl), .blb_rd(blb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err));

  sram_read_ctrl #(.ROWS(3), .COLS(2), .PRE_CYCLES(PRE), .WL_CYCLES(WL), .SENSE_MARGIN(0.4)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr3),
    .pre_en(pre_en3), .row_rd(row_rd3), .bl_rd(bl), .blb_rd(blb), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready3), .rsp_data(rsp_data3), .rsp_err(rsp_err3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference sense rule: returns {err, data} for one column.
  function automatic logic [1:0] sense_model(input real b, input real bb);
    real d;
    d = b - bb;
    if (d >= 0.4) return 2'b01;
    if (d <= -0.4) return 2'b00;
    return 2'b10;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bitlines();
    for (int c = 0; c < 2; c++) begin
      bl[c]  = real'($urandom_range(0, 150)) / 100.0;
      blb[c] = real'($urandom_range(0, 150)) / 100.0;
    end
  endtask

  // One full read on the ROWS=4 instance, checked cycle by cycle.
  task automatic read4(input int addr, input int hold);
    logic [1:0] s0, s1, exp_d, exp_e;
    logic [3:0] onehot;
    s0     = sense_model(bl[0], blb[0]);
    s1     = sense_model(bl[1], blb[1]);
    exp_d  = {s1[0], s0[0]};
    exp_e  = {s1[1], s0[1]};
    onehot = 4'b0001 << addr;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = 2'(addr);
    rsp_ready = (hold == 0);
    step();
    last_acc  = cyc;
    req_valid = 1'b0;
    req_addr  = 2'($urandom);
    for (int k = 1; k <= PRE + WL + 1; k++) begin
      check("seq_pre_en", 32'(pre_en), 32'(k <= PRE));
      check("seq_row_rd", 32'(row_rd), (k > PRE) ? 32'(onehot) : 32'd0);
      check("seq_rsp_valid", 32'(rsp_valid), 32'd0);
      check("seq_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    for (int h = 0; h < hold; h++) begin
      check("resp_valid", 32'(rsp_valid), 32'd1);
      check("resp_data", 32'(rsp_data), 32'(exp_d));
      check("resp_err", 32'(rsp_err), 32'(exp_e));
      check("resp_row_rd", 32'(row_rd), 32'd0);
      check("resp_req_ready", 32'(req_ready), 32'd0);
      rand_bitlines();
      step();
    end
    rsp_ready = 1'b1;
    check("resp_valid_last", 32'(rsp_valid), 32'd1);
    check("resp_data_last", 32'(rsp_data), 32'(exp_d));
    check("resp_err_last", 32'(rsp_err), 32'(exp_e));
    step();
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
    check("post_data_kept", 32'(rsp_data), 32'(exp_d));
    check("post_err_kept", 32'(rsp_err), 32'(exp_e));
    rsp_ready = 1'b0;
  endtask

  // Structural invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_pre_row_overlap", 32'(pre_en && (row_rd != 4'b0)), 32'd0);
      check("inv_row_onehot", 32'($countones(row_rd) <= 1), 32'd1);
    end
  end

  initial begin
    bl[0] = 1.5; bl[1] = 0.0; blb[0] = 0.0; blb[1] = 1.5;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_pre_en", 32'(pre_en), 32'd0);
    check("rst_row_rd", 32'(row_rd), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    step();
    step();
    rst = 1'b0;
    check("rel_req_ready_before_edge", 32'(req_ready), 32'd0);
    step();
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // Strong differentials, addr 2, response held for 10 cycles.
    read4(2, 10);

    // Weak differential on column 1 only.
    bl[0] = 1.5; blb[0] = 0.0; bl[1] = 0.9; blb[1] = 0.7;
    read4(1, 0);
    check("weak_err", 32'(rsp_err), 32'b10);
    check("weak_data", 32'(rsp_data), 32'b01);

    // Back-to-back reads with rsp_ready high on RESP entry.
    bl[0] = 0.0; blb[0] = 1.5; bl[1] = 1.5; blb[1] = 0.0;
    read4(0, 0);
    first_acc = last_acc;
    read4(1, 0);
    check("b2b_accept_spacing", 32'(last_acc - first_acc), 32'(PRE + WL + 3));

    // Out-of-range row on the ROWS=3 instance.
    check("r3_idle_ready", 32'(req_ready3), 32'd1);
    req_valid3 = 1'b1;
    req_addr3  = 2'd3;
    step();
    req_valid3 = 1'b0;
    check("r3_pre_en", 32'(pre_en3), 32'd0);
    check("r3_row_rd", 32'(row_rd3), 32'd0);
    check("r3_rsp_valid", 32'(rsp_valid3), 32'd1);
    check("r3_rsp_err", 32'(rsp_err3), 32'b11);
    check("r3_rsp_data", 32'(rsp_data3), 32'd0);
    rsp_ready3 = 1'b1;
    step();
    rsp_ready3 = 1'b0;
    check("r3_done_valid", 32'(rsp_valid3), 32'd0);
    check("r3_done_ready", 32'(req_ready3), 32'd1);

    // Reset asserted while the wordline is up.
    req_valid = 1'b1;
    req_addr  = 2'd3;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < PRE; k++) step();
    check("mid_wl_row", 32'(row_rd), 32'b1000);
    rst = 1'b1;
    #1;
    check("mid_rst_row", 32'(row_rd), 32'd0);
    check("mid_rst_pre", 32'(pre_en), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("mid_rel_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 8; k++) begin
      check("mid_no_rsp", 32'(rsp_valid), 32'd0);
      step();
    end

    // Randomized reads against the reference model.
    for (int i = 0; i < 16; i++) begin
      rand_bitlines();
      read4(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

endmodule
